debounce_edge_1bit: RTL and testbench

Synchronizes and debounces one asynchronous 1-bit input (push-button or switch) and produces a clean level plus single-cycle rise/fall strobes. It sits directly upstream of the 1-bit enable registers in the I/O path. o_rise or o_fall drives their enable input, so a held or bouncing button causes exactly one register update per press.

---
 rtl/debounce_edge_1bit.sv | 116 +++++++++++
 tb/tb_debounce_edge_1bit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_edge_1bit.sv
// Debounces one async input: 2-flop sync, then a run of STABLE_CYCLES equal samples commits.
// Level/strobe change STABLE_CYCLES+2 edges after the input settles; no backpressure, always accepts.
module debounce_edge_1bit #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW,
    S_WAIT_HIGH,
    S_HIGH,
    S_WAIT_LOW
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_s1;
  logic          r_s2;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic          w_level_nxt;
  logic          w_rise_nxt;
  logic          w_fall_nxt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Any sample breaking the run drops back to the settled state, so partial counts never carry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    unique case (r_state)
      S_LOW: begin
        if (r_s2) begin
          w_state_nxt = S_WAIT_HIGH;
          w_cnt_nxt   = CW'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (!r_s2) begin
          w_state_nxt = S_LOW;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_HIGH;
          w_level_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_HIGH: begin
        if (!r_s2) begin
          w_state_nxt = S_WAIT_LOW;
          w_cnt_nxt   = CW'(1);
        end
      end
      S_WAIT_LOW: begin
        if (r_s2) begin
          w_state_nxt = S_HIGH;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_LOW;
          w_level_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_LOW;
        w_level_nxt = 1'b0;
      end
    endcase
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: tb/tb_debounce_edge_1bit.sv
// Bench for debounce_edge_1bit: directed scenarios plus random bounce, checked against a sample-history model.
module tb_debounce_edge_1bit;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst4 = 1'b0;
  logic rst16 = 1'b0;
  logic raw4 = 1'b0;
  logic raw16 = 1'b0;
  logic level4, rise4, fall4;
  logic level16, rise16, fall16;

  int checks = 0;
  int failures = 0;

  // Model state per instance: 0 -> STABLE_CYCLES=4, 1 -> STABLE_CYCLES=16.
  bit raw_h[2][8192];
  int n_edges[2];
  bit m_lvl[2];
  bit m_rise[2];
  bit m_fall[2];

  debounce_edge_1bit #(.STABLE_CYCLES(4)) dut4 (
    .i_clk(clk), .i_reset(rst4), .i_raw(raw4),
    .o_level(level4), .o_rise(rise4), .o_fall(fall4)
  );

  debounce_edge_1bit #(.STABLE_CYCLES(16)) dut16 (
    .i_clk(clk), .i_reset(rst16), .i_raw(raw16),
    .o_level(level16), .o_rise(rise16), .o_fall(fall16)
  );

  always #5 if (clk_en) clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  task automatic model_clear(input int k);
    n_edges[k] = 0;
    m_lvl[k] = 1'b0;
    m_rise[k] = 1'b0;
    m_fall[k] = 1'b0;
  endtask

  // Sample the FSM sees at edge e: the raw value captured two edges earlier, 0 until then.
  function automatic bit sample_at(input int k, input int e);
    return (e >= 3) ? raw_h[k][e-3] : 1'b0;
  endfunction

  // Level flips when the last sc FSM samples all disagree with the current level.
  task automatic model_edge(input int k, input int sc, input bit raw, input bit rst);
    int run;
    int e;
    m_rise[k] = 1'b0;
    m_fall[k] = 1'b0;
    if (rst) begin
      model_clear(k);
      return;
    end
    raw_h[k][n_edges[k]] = raw;
    n_edges[k]++;
    run = 0;
    e = n_edges[k];
    while (e >= 1 && run < sc && sample_at(k, e) != m_lvl[k]) begin
      run++;
      e--;
    end
    if (run == sc) begin
      m_lvl[k] = ~m_lvl[k];
      if (m_lvl[k]) m_rise[k] = 1'b1;
      else m_fall[k] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0, 4, raw4, rst4);
    model_edge(1, 16, raw16, rst16);
    #1;
  endtask

  task automatic test_reset();
    #3;
    rst4 = 1'b1;
    rst16 = 1'b1;
    model_clear(0);
    model_clear(1);
    #1;
    checks++;
    if ({level4, rise4, fall4} !== 3'b000) begin
      failures++;
      $display("FAIL reset_async_dut4: got %b expected 000", {level4, rise4, fall4});
    end
    checks++;
    if ({level16, rise16, fall16} !== 3'b000) begin
      failures++;
      $display("FAIL reset_async_dut16: got %b expected 000", {level16, rise16, fall16});
    end
    clk_en = 1'b1;
    repeat (3) step();
    rst4 = 1'b0;
    rst16 = 1'b0;
    for (int e = 1; e <= 50; e++) begin
      step();
      checks++;
      if ({level4, rise4, fall4, level16, rise16, fall16} !== 6'b0) begin
        failures++;
        $display("FAIL reset_idle edge %0d: got %b expected 000000", e,
                 {level4, rise4, fall4, level16, rise16, fall16});
      end
    end
  endtask

  task automatic test_clean_press();
    raw4 = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      checks++;
      if ({level4, rise4, fall4} !== {1'(e >= 6), 1'(e == 6), 1'b0}) begin
        failures++;
        $display("FAIL clean_press edge %0d: got lvl/rise/fall=%b expected %b", e,
                 {level4, rise4, fall4}, {1'(e >= 6), 1'(e == 6), 1'b0});
      end
      checks++;
      if ({level4, rise4, fall4} !== {m_lvl[0], m_rise[0], m_fall[0]}) begin
        failures++;
        $display("FAIL clean_press_model edge %0d: got %b expected %b", e,
                 {level4, rise4, fall4}, {m_lvl[0], m_rise[0], m_fall[0]});
      end
    end
  endtask

  task automatic test_release();
    raw4 = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      checks++;
      if ({level4, rise4, fall4} !== {1'(e < 6), 1'b0, 1'(e == 6)}) begin
        failures++;
        $display("FAIL release_fall edge %0d: got %b expected %b", e,
                 {level4, rise4, fall4}, {1'(e < 6), 1'b0, 1'(e == 6)});
      end
    end
    raw4 = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      checks++;
      if ({level4, rise4, fall4} !== {1'(e >= 6), 1'(e == 6), 1'b0}) begin
        failures++;
        $display("FAIL release_rerise edge %0d: got %b expected %b", e,
                 {level4, rise4, fall4}, {1'(e >= 6), 1'(e == 6), 1'b0});
      end
    end
    raw4 = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      checks++;
      if ({level4, rise4, fall4} !== {m_lvl[0], m_rise[0], m_fall[0]}) begin
        failures++;
        $display("FAIL release_back_low edge %0d: got %b expected %b", e,
                 {level4, rise4, fall4}, {m_lvl[0], m_rise[0], m_fall[0]});
      end
    end
  endtask

  task automatic test_glitch();
    int seen = 0;
    for (int e = 1; e <= 15; e++) begin
      raw4 = (e <= 3);
      step();
      if (level4 || rise4 || fall4) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL glitch_reject: got %0d active edges expected 0", seen);
    end
    raw4 = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if ({level4, rise4} !== {1'(e >= 6), 1'(e == 6)}) begin
        failures++;
        $display("FAIL glitch_fresh_press edge %0d: got %b expected %b", e,
                 {level4, rise4}, {1'(e >= 6), 1'(e == 6)});
      end
    end
    raw4 = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_bounce();
    logic [4:0] pat = 5'b01101;
    int rises = 0;
    int rise_at = 0;
    for (int e = 1; e <= 18; e++) begin
      raw4 = (e <= 5) ? pat[e-1] : 1'b1;
      step();
      if (rise4) begin
        rises++;
        rise_at = e;
      end
      checks++;
      if ({level4, rise4, fall4} !== {m_lvl[0], m_rise[0], m_fall[0]}) begin
        failures++;
        $display("FAIL bounce_model edge %0d: got %b expected %b", e,
                 {level4, rise4, fall4}, {m_lvl[0], m_rise[0], m_fall[0]});
      end
    end
    checks++;
    if (rises !== 1 || rise_at !== 11) begin
      failures++;
      $display("FAIL bounce_single_rise: got %0d rises at edge %0d expected 1 at edge 11", rises, rise_at);
    end
    raw4 = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_back_to_back();
    int rise_at = 0;
    int fall_at = 0;
    for (int e = 1; e <= 14; e++) begin
      raw4 = (e <= 4);
      step();
      if (rise4) rise_at = e;
      if (fall4) fall_at = e;
    end
    checks++;
    if (rise_at !== 6 || fall_at !== 10) begin
      failures++;
      $display("FAIL back_to_back: got rise@%0d fall@%0d expected rise@6 fall@10", rise_at, fall_at);
    end
  endtask

  task automatic test_reset_midqual();
    int rise_at = 0;
    raw16 = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      checks++;
      if ({level16, rise16, fall16} !== 3'b000) begin
        failures++;
        $display("FAIL midqual_pre edge %0d: got %b expected 000", e, {level16, rise16, fall16});
      end
    end
    rst16 = 1'b1;
    model_clear(1);
    #1;
    repeat (2) step();
    checks++;
    if ({level16, rise16, fall16} !== 3'b000) begin
      failures++;
      $display("FAIL midqual_in_reset: got %b expected 000", {level16, rise16, fall16});
    end
    rst16 = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      step();
      if (rise16 && rise_at == 0) rise_at = e;
      checks++;
      if ({level16, rise16, fall16} !== {m_lvl[1], m_rise[1], m_fall[1]}) begin
        failures++;
        $display("FAIL midqual_model edge %0d: got %b expected %b", e,
                 {level16, rise16, fall16}, {m_lvl[1], m_rise[1], m_fall[1]});
      end
    end
    checks++;
    if (rise_at !== 18) begin
      failures++;
      $display("FAIL midqual_rise_edge: got %0d expected 18 (0 = never)", rise_at);
    end
  endtask

  task automatic test_random();
    int hold4 = 0;
    int hold16 = 0;
    for (int c = 0; c < 800; c++) begin
      if (rst16) begin
        rst16 = 1'b0;
      end else if ($urandom_range(0, 249) == 0) begin
        rst16 = 1'b1;
        model_clear(1);
        #1;
        checks++;
        if ({level16, rise16, fall16} !== 3'b000) begin
          failures++;
          $display("FAIL random_async_reset cycle %0d: got %b expected 000", c, {level16, rise16, fall16});
        end
      end
      if (hold4 == 0) begin
        raw4 = ~raw4;
        hold4 = $urandom_range(1, 7);
      end
      if (hold16 == 0) begin
        raw16 = ~raw16;
        hold16 = ($urandom_range(0, 3) == 0) ? $urandom_range(14, 22) : $urandom_range(1, 18);
      end
      hold4--;
      hold16--;
      step();
      checks++;
      if ({level4, rise4, fall4} !== {m_lvl[0], m_rise[0], m_fall[0]}) begin
        failures++;
        $display("FAIL random_dut4 cycle %0d: got %b expected %b", c,
                 {level4, rise4, fall4}, {m_lvl[0], m_rise[0], m_fall[0]});
      end
      checks++;
      if ({level16, rise16, fall16} !== {m_lvl[1], m_rise[1], m_fall[1]}) begin
        failures++;
        $display("FAIL random_dut16 cycle %0d: got %b expected %b", c,
                 {level16, rise16, fall16}, {m_lvl[1], m_rise[1], m_fall[1]});
      end
      checks++;
      if ((rise4 && fall4) || (rise16 && fall16)) begin
        failures++;
        $display("FAIL random_both_strobes cycle %0d: got %b%b expected not both", c,
                 rise4 & fall4, rise16 & fall16);
      end
    end
  endtask

  initial begin
    model_clear(0);
    model_clear(1);
    test_reset();
    test_clean_press();
    test_release();
    test_glitch();
    test_bounce();
    test_back_to_back();
    test_reset_midqual();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
